// File: rtl/chan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chan_mux_pkg
// Brief    : Shared mode encodings and index-width helper for chan_mux_rr.
// Revision : 1.0 - initial release
// ============================================================================
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for a channel count; callers guarantee value >= 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational find-first-set over req, starting at ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import chan_mux_pkg::*;
#(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int w_idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            // ptr is always kept below N, so a single subtraction wraps it.
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/chan_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : chan_mux_rr
// Brief    : N-channel registered stream mux, fixed-select or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int WIDTH = 8,
    localparam int SEL_W = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PAD_N = 1 << SEL_W;

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [PAD_N-1:0] w_valid_pad;
    logic             w_sel_ok;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_load;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SEL_W-1:0] w_ptr_next;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req       (in_valid),
        .ptr       (r_ptr),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    // Padding lets sel index safely when N is not a power of two.
    assign w_valid_pad = PAD_N'(in_valid);
    assign w_sel_ok    = (int'(sel) < N);

    always_comb begin
        if (mode == MODE_RR) begin
            w_gnt_valid = w_rr_valid;
            w_gnt_idx   = w_rr_idx;
        end else begin
            w_gnt_valid = w_sel_ok && w_valid_pad[sel];
            w_gnt_idx   = sel;
        end
    end

    assign w_load = !r_out_valid || out_ready;
    assign w_xfer = w_load && w_gnt_valid && !rst;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ready
            assign in_ready[i] = w_xfer && (w_gnt_idx == SEL_W'(i));
        end
    endgenerate

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (int'(w_gnt_idx) == N - 1) ? '0 : w_gnt_idx + 1'b1;

    // A transfer always wins over a drain, so load+drain in one cycle keeps valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_data;
            r_out_chan  <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_chan_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_chan_mux_rr
// Brief    : Directed scoreboard bench for chan_mux_rr at N=16 and N=12.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chan_mux_rr;

    logic         clk;
    logic         rst;

    logic         mode16, mode12;
    logic [3:0]   sel16, sel12;
    logic [127:0] data16;
    logic [95:0]  data12;
    logic [15:0]  valid16, ready16;
    logic [11:0]  valid12, ready12;
    logic [7:0]   od16, od12;
    logic [3:0]   oc16, oc12;
    logic         ov16, ov12;
    logic         or16, or12;

    int tests;
    int fails;

    logic [11:0] q16[$];
    logic [11:0] q12[$];
    bit          ev[2];
    logic [7:0]  ed[2];
    logic [3:0]  ec[2];

    chan_mux_rr #(.N(16), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode16), .sel(sel16),
        .in_data(data16), .in_valid(valid16), .in_ready(ready16),
        .out_data(od16), .out_chan(oc16), .out_valid(ov16), .out_ready(or16)
    );

    chan_mux_rr #(.N(12), .WIDTH(8)) dut12 (
        .clk(clk), .rst(rst), .mode(mode12), .sel(sel12),
        .in_data(data12), .in_valid(valid12), .in_ready(ready12),
        .out_data(od12), .out_chan(oc12), .out_valid(ov12), .out_ready(or12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check in_ready, queue any expected word, then
    // check the output register after the edge.
    task automatic step(input bit d, input logic m, input logic [3:0] s,
                        input logic [15:0] v, input logic r, input logic [15:0] er,
                        input bit push, input int ch, input string tag);
        logic        load_pre;
        logic [11:0] w;
        if (!d) begin
            mode16 = m; sel16 = s; valid16 = v; or16 = r;
        end else begin
            mode12 = m; sel12 = s; valid12 = v[11:0]; or12 = r;
        end
        #1;
        check({tag, " in_ready"}, d ? {20'b0, ready12} : {16'b0, ready16}, {16'b0, er});
        load_pre = !ev[d] || r;
        if (push) begin
            if (!d) q16.push_back({8'hA0 + 8'(ch), 4'(ch)});
            else    q12.push_back({8'h50 + 8'(ch), 4'(ch)});
        end
        @(posedge clk);
        #1;
        if (load_pre) begin
            if (!d && q16.size() > 0) begin
                w = q16.pop_front(); ev[d] = 1'b1; ed[d] = w[11:4]; ec[d] = w[3:0];
            end else if (d && q12.size() > 0) begin
                w = q12.pop_front(); ev[d] = 1'b1; ed[d] = w[11:4]; ec[d] = w[3:0];
            end else begin
                ev[d] = 1'b0;
            end
        end
        check({tag, " out_valid"}, d ? 32'(ov12) : 32'(ov16), 32'(ev[d]));
        if (ev[d]) begin
            check({tag, " out_data"}, d ? 32'(od12) : 32'(od16), 32'(ed[d]));
            check({tag, " out_chan"}, d ? 32'(oc12) : 32'(oc16), 32'(ec[d]));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ev[0] = 1'b0; ev[1] = 1'b0;
        ed[0] = '0; ed[1] = '0; ec[0] = '0; ec[1] = '0;
        for (int i = 0; i < 16; i++) data16[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 12; i++) data12[i*8 +: 8] = 8'h50 + 8'(i);
        rst = 1'b1;
        mode16 = 1'b1; sel16 = '0; valid16 = 16'hFFFF; or16 = 1'b1;
        mode12 = 1'b0; sel12 = '0; valid12 = '0; or12 = 1'b1;

        #12;
        check("por out_valid", 32'(ov16), 32'(0));
        check("por out_data", 32'(od16), 32'(0));
        check("por out_chan", 32'(oc16), 32'(0));
        check("por in_ready", 32'(ready16), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // First round-robin grant after reset comes from channel 0.
        step(0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0001, 1, 0, "rr_first");

        step(0, 1'b0, 4'd0,  16'hFFFF, 1'b1, 16'h0001, 1, 0,  "fix0");
        step(0, 1'b0, 4'd1,  16'hFFFF, 1'b1, 16'h0002, 1, 1,  "fix1");
        step(0, 1'b0, 4'd6,  16'hFFFF, 1'b1, 16'h0040, 1, 6,  "fix6");
        step(0, 1'b0, 4'd12, 16'hFFFF, 1'b1, 16'h1000, 1, 12, "fix12");
        step(0, 1'b0, 4'd6,  16'hFFBF, 1'b1, 16'h0000, 0, 0,  "fix_nogrant");

        // Serving channel 15 in fixed mode wraps ptr back to 0.
        step(0, 1'b0, 4'd15, 16'h8421, 1'b1, 16'h8000, 1, 15, "fix15");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h0001, 1, 0,  "rr_a0");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h0020, 1, 5,  "rr_a5");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h0400, 1, 10, "rr_a10");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h8000, 1, 15, "rr_a15");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h0001, 1, 0,  "rr_b0");
        step(0, 1'b1, 4'd0, 16'h8401, 1'b1, 16'h0400, 1, 10, "rr_skip5");
        step(0, 1'b1, 4'd0, 16'h8401, 1'b1, 16'h8000, 1, 15, "rr_b15");
        step(0, 1'b1, 4'd0, 16'h8401, 1'b1, 16'h0001, 1, 0,  "rr_c0");

        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h0020, 1, 5,  "bp_load");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b0, 16'h0000, 0, 0,  "bp_stall1");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b0, 16'h0000, 0, 0,  "bp_stall2");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b0, 16'h0000, 0, 0,  "bp_stall3");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h0400, 1, 10, "bp_release");
        step(0, 1'b1, 4'd0, 16'h0000, 1'b1, 16'h0000, 0, 0,  "drain");
        step(0, 1'b1, 4'd0, 16'h8421, 1'b1, 16'h8000, 1, 15, "pre_rst");

        // Non-power-of-two channel count.
        step(1, 1'b0, 4'd13, 16'h0FFF, 1'b1, 16'h0000, 0, 0,  "n12_sel13");
        step(1, 1'b0, 4'd11, 16'h0FFF, 1'b1, 16'h0800, 1, 11, "n12_sel11");
        step(1, 1'b1, 4'd11, 16'h0FFF, 1'b1, 16'h0001, 1, 0,  "n12_rr_wrap");
        step(1, 1'b1, 4'd0,  16'h0000, 1'b1, 16'h0000, 0, 0,  "n12_drain");

        // Reset while a word is held must clear everything immediately.
        or16 = 1'b0;
        #1;
        check("hold out_valid", 32'(ov16), 32'(1));
        rst = 1'b1;
        #1;
        check("rst out_valid", 32'(ov16), 32'(0));
        check("rst out_data", 32'(od16), 32'(0));
        check("rst out_chan", 32'(oc16), 32'(0));
        check("rst in_ready", 32'(ready16), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        ev[0] = 1'b0;
        q16.delete();
        step(0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h0001, 1, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
